// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiplier read-side blocks:
// default element width, stream state encoding and a width helper.
package matrix_pkg;

   localparam int DEF_DATA_W = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } stream_state_t;

   // Index width for a dimension of size n; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/matrix_result_streamer_rc_counter.sv
// Row/column wrap counter walking a ROWS x COLS grid in row-major order,
// with end-of-row and final-element flags.
module rc_counter
   import matrix_pkg::*;
#(
   parameter int ROWS = 2,
   parameter int COLS = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clear,
   input  logic                      advance,
   output logic [idx_w(ROWS)-1:0]    row,
   output logic [idx_w(COLS)-1:0]    col,
   output logic                      eol,
   output logic                      last
);

   assign eol  = (int'(col) == COLS - 1);
   assign last = eol && (int'(row) == ROWS - 1);

   // clear wins over advance so a fresh walk always starts at (0,0).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (eol) begin
            col <= '0;
            row <= last ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/matrix_result_streamer.sv
// Snapshots the multiplier result array on start and streams it out
// row-major, one element per valid/ready handshake.
module matrix_result_streamer
   import matrix_pkg::*;
#(
   parameter int Col1   = 2,
   parameter int Row2   = 2,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DATA_W-1:0]         c [Col1*Row2],
   input  logic                      start,
   input  logic                      abort,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_W-1:0]         m_data,
   output logic [idx_w(Col1)-1:0]    m_row,
   output logic [idx_w(Row2)-1:0]    m_col,
   output logic                      m_eol,
   output logic                      m_last,
   output logic                      busy,
   output logic                      done
);

   localparam int N = Col1 * Row2;

   stream_state_t state, state_nxt;
   logic [DATA_W-1:0] buffer [N];
   logic              capture;
   logic              advance;
   logic              finish;
   logic              cnt_eol;
   logic              cnt_last;
   logic [DATA_W-1:0] rd_data;
   int                rd_idx;

   // Handshake: an element moves when m_valid && m_ready at a rising edge;
   // while m_valid && !m_ready every m_* output holds. m_valid never drops
   // without a transfer except on abort or reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= finish;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      advance   = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = STREAM;
               capture   = 1'b1;
            end
         end
         STREAM: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (m_ready) begin
               advance = 1'b1;
               if (cnt_last) begin
                  state_nxt = IDLE;
                  finish    = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The buffer decouples the stream from c, which may change after start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) buffer[i] <= '0;
      end else if (capture) begin
         for (int i = 0; i < N; i++) buffer[i] <= c[i];
      end
   end

   rc_counter #(
      .ROWS (Col1),
      .COLS (Row2)
   ) u_rc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (capture),
      .advance (advance),
      .row     (m_row),
      .col     (m_col),
      .eol     (cnt_eol),
      .last    (cnt_last)
   );

   always_comb begin
      rd_idx  = int'(m_row) * Row2 + int'(m_col);
      rd_data = '0;
      for (int i = 0; i < N; i++) begin
         if (i == rd_idx) rd_data = buffer[i];
      end
   end

   // Flags are gated so a 1-wide row does not show eol while idle.
   assign m_valid = (state == STREAM);
   assign busy    = (state == STREAM);
   assign m_data  = m_valid ? rd_data : '0;
   assign m_eol   = m_valid && cnt_eol;
   assign m_last  = m_valid && cnt_last;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Bench for matrix_result_streamer: 2x2, 3x1 and 1x1 instances share the
// control inputs and are checked each cycle against a transaction-level model.
module tb_matrix_result_streamer;

   localparam int W = 16;
   localparam int NR [3] = '{2, 3, 1};
   localparam int NC [3] = '{2, 1, 1};

   logic clk = 1'b0;
   logic rst_n;
   logic start, abort, m_ready;

   logic [W-1:0] c22 [4];
   logic [W-1:0] c31 [3];
   logic [W-1:0] c11 [1];

   logic         v22, v31, v11;
   logic [W-1:0] d22, d31, d11;
   logic [0:0]   r22, r11;
   logic [1:0]   r31;
   logic [0:0]   k22, k31, k11;
   logic         e22, e31, e11, l22, l31, l11;
   logic         b22, b31, b11, dn22, dn31, dn11;

   int n_vec = 0;
   int n_miss = 0;

   // Reference model: captured snapshot plus position within the stream.
   logic [W-1:0] snap [3][4];
   int           ptr  [3];
   bit           act  [3];
   bit           dexp [3];

   always #5 clk = ~clk;

   matrix_result_streamer #(.Col1(2), .Row2(2), .DATA_W(W)) u22 (
      .clk(clk), .rst_n(rst_n), .c(c22), .start(start), .abort(abort),
      .m_valid(v22), .m_ready(m_ready), .m_data(d22), .m_row(r22), .m_col(k22),
      .m_eol(e22), .m_last(l22), .busy(b22), .done(dn22));

   matrix_result_streamer #(.Col1(3), .Row2(1), .DATA_W(W)) u31 (
      .clk(clk), .rst_n(rst_n), .c(c31), .start(start), .abort(abort),
      .m_valid(v31), .m_ready(m_ready), .m_data(d31), .m_row(r31), .m_col(k31),
      .m_eol(e31), .m_last(l31), .busy(b31), .done(dn31));

   matrix_result_streamer #(.Col1(1), .Row2(1), .DATA_W(W)) u11 (
      .clk(clk), .rst_n(rst_n), .c(c11), .start(start), .abort(abort),
      .m_valid(v11), .m_ready(m_ready), .m_data(d11), .m_row(r11), .m_col(k11),
      .m_eol(e11), .m_last(l11), .busy(b11), .done(dn11));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] cval(input int i, input int k);
      case (i)
         0:       return c22[k];
         1:       return c31[k];
         default: return c11[0];
      endcase
   endfunction

   task automatic check_inst(input int i, input bit in_reset,
                             input logic [31:0] v, input logic [31:0] d,
                             input logic [31:0] r, input logic [31:0] cl,
                             input logic [31:0] e, input logic [31:0] l,
                             input logic [31:0] b, input logic [31:0] dn);
      int n;
      n = NR[i] * NC[i];
      if (in_reset) begin
         check($sformatf("rst_valid%0d", i), v, 0);
         check($sformatf("rst_data%0d", i), d, 0);
         check($sformatf("rst_row%0d", i), r, 0);
         check($sformatf("rst_col%0d", i), cl, 0);
         check($sformatf("rst_eol%0d", i), e, 0);
         check($sformatf("rst_last%0d", i), l, 0);
         check($sformatf("rst_busy%0d", i), b, 0);
         check($sformatf("rst_done%0d", i), dn, 0);
      end else begin
         check($sformatf("valid%0d", i), v, 32'(act[i]));
         check($sformatf("busy%0d", i), b, 32'(act[i]));
         check($sformatf("done%0d", i), dn, 32'(dexp[i]));
         if (act[i]) begin
            check($sformatf("data%0d", i), d, 32'(snap[i][ptr[i]]));
            check($sformatf("row%0d", i), r, 32'(ptr[i] / NC[i]));
            check($sformatf("col%0d", i), cl, 32'(ptr[i] % NC[i]));
            check($sformatf("eol%0d", i), e, 32'((ptr[i] % NC[i]) == NC[i] - 1));
            check($sformatf("last%0d", i), l, 32'(ptr[i] == n - 1));
         end
      end
   endtask

   task automatic check_all(input bit in_reset);
      check_inst(0, in_reset, 32'(v22), 32'(d22), 32'(r22), 32'(k22), 32'(e22), 32'(l22), 32'(b22), 32'(dn22));
      check_inst(1, in_reset, 32'(v31), 32'(d31), 32'(r31), 32'(k31), 32'(e31), 32'(l31), 32'(b31), 32'(dn31));
      check_inst(2, in_reset, 32'(v11), 32'(d11), 32'(r11), 32'(k11), 32'(e11), 32'(l11), 32'(b11), 32'(dn11));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         act[i]  = 1'b0;
         dexp[i] = 1'b0;
         ptr[i]  = 0;
      end
   endtask

   // One clock of stream behaviour for each instance, from the inputs at the edge.
   task automatic model_update();
      for (int i = 0; i < 3; i++) begin
         int n;
         n = NR[i] * NC[i];
         dexp[i] = 1'b0;
         if (!act[i]) begin
            if (start) begin
               act[i] = 1'b1;
               ptr[i] = 0;
               for (int k = 0; k < n; k++) snap[i][k] = cval(i, k);
            end
         end else if (abort) begin
            act[i] = 1'b0;
         end else if (m_ready) begin
            if (ptr[i] == n - 1) begin
               act[i]  = 1'b0;
               dexp[i] = 1'b1;
            end else begin
               ptr[i]++;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all(1'b0);
   endtask

   task automatic set_basic();
      c22[0] = 16'd7; c22[1] = 16'd10; c22[2] = 16'd15; c22[3] = 16'd22;
      c31[0] = 16'd1; c31[1] = 16'd2;  c31[2] = 16'd3;
      c11[0] = 16'hBEEF;
   endtask

   task automatic set_all(input logic [W-1:0] val);
      for (int k = 0; k < 4; k++) c22[k] = val;
      for (int k = 0; k < 3; k++) c31[k] = val;
      c11[0] = val;
   endtask

   task automatic set_random();
      for (int k = 0; k < 4; k++) c22[k] = W'($urandom);
      for (int k = 0; k < 3; k++) c31[k] = W'($urandom);
      c11[0] = W'($urandom);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0;
      set_random();
      model_reset();
      repeat (3) @(negedge clk);
      check_all(1'b1);
      rst_n = 1'b1;
      repeat (3) step();

      // Basic stream with the consumer always ready.
      set_basic();
      m_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      repeat (6) step();

      // Backpressure, with c overwritten right after capture.
      start = 1'b1; step(); start = 1'b0;
      set_all(16'hFFFF);
      for (int k = 0; k < 14; k++) begin
         m_ready = (k % 3 == 0);
         step();
      end

      // Start re-pulsed mid-stream, then abort after the second handshake.
      set_basic();
      m_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step();
      abort = 1'b1; step(); abort = 1'b0;
      step();
      start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
      repeat (5) step();

      // Randomized traffic.
      for (int k = 0; k < 500; k++) begin
         start   = ($urandom_range(0, 3) == 0);
         abort   = ($urandom_range(0, 15) == 0);
         m_ready = ($urandom_range(0, 2) != 0);
         set_random();
         step();
      end
      start = 1'b0; abort = 1'b0; m_ready = 1'b1;
      repeat (6) step();

      // Asynchronous reset between edges while streaming.
      set_random();
      m_ready = 1'b0;
      start = 1'b1; step(); start = 1'b0;
      step();
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all(1'b1);
      @(posedge clk);
      @(negedge clk);
      check_all(1'b1);
      rst_n = 1'b1;
      m_ready = 1'b1;
      set_basic();
      start = 1'b1; step(); start = 1'b0;
      repeat (5) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/matrix_result_streamer.md
Name: matrix_result_streamer

Overview:
Reads the flat result array produced by the combinational matrix multiplier and streams it out one element per handshake, row-major, over a valid/ready interface. On a start pulse it snapshots the whole array into an internal buffer, so the multiplier inputs may change immediately afterwards. It is the read-side counterpart of the multiplier and sits between the multiplier output and the downstream consumer (UART/host link or FIFO).

Parameters:
Col1, 2, number of result rows (matches multiplier Col1)
Row2, 2, number of result columns (matches multiplier Row2)
DATA_W, 16, element width in bits

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
c  input  DATA_W x (Col1*Row2) unpacked  result array, element index i*Row2+k
start  input  1  capture-and-stream request, sampled in IDLE only
abort  input  1  synchronous cancel of an in-progress stream
m_valid  output  1  element available
m_ready  input  1  downstream accepts element
m_data  output  DATA_W  current element
m_row  output  max(1,$clog2(Col1))  row index of m_data
m_col  output  max(1,$clog2(Row2))  column index of m_data
m_eol  output  1  m_data is the last element of its row
m_last  output  1  m_data is the final element (row Col1-1, col Row2-1)
busy  output  1  high in STREAM
done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (rst_n low, async): state IDLE; m_valid, m_data, m_row, m_col, m_eol, m_last, busy, done all 0; buffer contents 0.
- States: IDLE, STREAM.
- IDLE: start=1 at edge -> buffer <= c (all elements), row=col=0, state STREAM. m_valid=1, busy=1 from that edge (one-cycle latency start->first valid).
- STREAM: m_data=buf[row*Row2+col]; m_eol=(col==Row2-1); m_last=m_eol&&(row==Col1-1). Outputs are registered or derived from registers only, never from c.
- Handshake: transfer when m_valid&&m_ready at an edge. On transfer, col increments; at col==Row2-1 col wraps to 0 and row increments. m_data/m_row/m_col remain stable while m_valid&&!m_ready.
- Final transfer (m_last&&m_ready): state IDLE, m_valid=0, busy=0, done=1 for exactly the following cycle.
- start while in STREAM, including the cycle of the final handshake: ignored (no queuing). start in the cycle done is high is accepted.
- abort=1 in STREAM: next edge -> IDLE, m_valid=0, busy=0, done stays 0. It takes priority over a coincident handshake. abort in IDLE has no effect. If start and abort are both high in IDLE, start wins.
- Col1*Row2==1: the first element has m_eol=m_last=1. One handshake completes the stream.
- No arithmetic on data. Elements pass through bit-exact.
- Async reset mid-stream: immediate return to reset values. No done.

Decomposition:
- Shared package matrix_pkg: DATA_W default, stream state enum (IDLE, STREAM), clog2-safe width helper function.
- Single module. No sub-module needed. The row/col counter pair is inline. An optional sub-module is rc_counter (row/col wrap counter with eol/last flags), usable later by a matrix loader.

Test Plan:
- Reset: hold rst_n=0 with random c -> all outputs 0; release, no start -> m_valid stays 0.
- Basic 2x2: c={7,10,15,22}, start pulse, m_ready=1 -> m_valid rises 1 cycle after start; data 7,10,15,22 on consecutive cycles; (row,col)=(0,0),(0,1),(1,0),(1,1); m_eol on 10 and 22; m_last on 22; done pulse on the cycle after 22; busy low.
- Backpressure/snapshot: same c, m_ready toggles 1,0,0,1,... and c changed to all 0xFFFF after start -> output sequence still 7,10,15,22; m_data held stable during every ready-low cycle; no duplicated or skipped elements.
- Start ignored/abort: start re-pulsed mid-stream -> no restart. Abort after the second handshake -> m_valid=0 next cycle, no done. Then a new start streams from element 0.
- Non-square Col1=3, Row2=1, c={1,2,3} -> every element has m_eol=1, m_last only on 3. Col1=Row2=1, c={0xBEEF} -> a single element with m_last=1, then done.
- Async reset mid-stream: assert rst_n low between clock edges while m_valid=1 -> outputs go to 0 immediately, not at the next edge.
